// File: rtl/tile_renderer.sv
// tile_renderer: 16x12 colour-index tile map feeding the VGA block, with tile writes buffered and committed in vblank.
// Optional macro GRID_LINES_EN overlays 4'h2 grid lines on tile borders.

module tile_renderer (
   input  logic       vgaclk,
   input  logic       rst,
   input  logic [9:0] hc,
   input  logic [9:0] vc,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic [3:0] wr_col,
   input  logic [3:0] wr_row,
   input  logic [3:0] wr_color,
   output logic       oob_flag,
   output logic       frame_start,
   output logic [3:0] red_out,
   output logic [3:0] green_out,
   output logic [3:0] blue_out
);

   localparam int unsigned BSIZE      = 40;
   localparam int unsigned COLS       = 16;
   localparam int unsigned ROWS       = 12;
   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned HTOTAL     = 800;
   localparam int unsigned VTOTAL     = 525;
   localparam int unsigned HW         = 10;
   localparam int unsigned NTILES     = COLS * ROWS;
   localparam int unsigned AW         = $clog2(NTILES);
   localparam int unsigned PW         = $clog2(FIFO_DEPTH);
   localparam int unsigned CW         = PW + 1;
   localparam int unsigned HACT       = COLS * BSIZE;
   localparam int unsigned VACT       = ROWS * BSIZE;

   typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

   state_t        state;
   logic [AW-1:0] clr_idx;
   logic [3:0]    map_q  [NTILES];
   logic [11:0]   fifo_q [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;

   logic          push_c;
   logic          pop_c;
   logic          head_ok_c;
   logic [CW-1:0] count_next_c;
   logic [3:0]    head_col_c;
   logic [3:0]    head_row_c;
   logic [3:0]    head_color_c;

   function automatic logic [11:0] palette(input logic [3:0] idx);
      logic [3:0] lvl;
      lvl = idx[3] ? 4'hF : 4'h8;
      return {idx[2] ? lvl : 4'h0, idx[1] ? lvl : 4'h0, idx[0] ? lvl : 4'h0};
   endfunction

   // Write FIFO: pushes whenever ready, pops only in vertical blanking
   assign {head_col_c, head_row_c, head_color_c} = fifo_q[rd_ptr];
   assign push_c       = wr_valid & wr_ready;
   assign pop_c        = (state == S_RUN) && (vc >= HW'(VACT)) && (count != '0);
   assign head_ok_c    = ({1'b0, head_col_c} < 5'(COLS)) && ({1'b0, head_row_c} < 5'(ROWS));
   assign count_next_c = count + CW'(push_c) - CW'(pop_c);

   logic          map_we_c;
   logic [AW-1:0] map_wa_c;
   logic [3:0]    map_wd_c;

   always_comb begin
      map_we_c = 1'b0;
      map_wa_c = '0;
      map_wd_c = '0;
      if (state == S_CLEAR) begin
         map_we_c = 1'b1;
         map_wa_c = clr_idx;
      end else if (pop_c && head_ok_c) begin
         map_we_c = 1'b1;
         map_wa_c = AW'(32'(head_row_c) * COLS + 32'(head_col_c));
         map_wd_c = head_color_c;
      end
   end

   // Storage arrays carry no reset; CLEAR and the FIFO pointers give them meaning
   always_ff @(posedge vgaclk) begin
      if (map_we_c) map_q[map_wa_c] <= map_wd_c;
      if (push_c) fifo_q[wr_ptr] <= {wr_col, wr_row, wr_color};
   end

   // Look-ahead pixel position so the registered colour lines up with (hc,vc)
   logic [HW-1:0] nh_c;
   logic [HW-1:0] nv_c;
   logic [HW-1:0] tcol_c;
   logic [HW-1:0] trow_c;
   logic          active_c;
   logic [AW-1:0] rd_idx_c;
   logic [11:0]   pix_c;

   always_comb begin
      nh_c = hc + 10'd1;
      nv_c = vc;
      if (hc == HW'(HTOTAL - 1)) begin
         nh_c = '0;
         nv_c = (vc == HW'(VTOTAL - 1)) ? '0 : vc + 10'd1;
      end
      active_c = (nh_c < HW'(HACT)) && (nv_c < HW'(VACT));
      tcol_c   = nh_c / HW'(BSIZE);
      trow_c   = nv_c / HW'(BSIZE);
      rd_idx_c = '0;
      pix_c    = '0;
      if (active_c) begin
         rd_idx_c = AW'(trow_c * HW'(COLS) + tcol_c);
         pix_c    = palette(map_q[rd_idx_c]);
`ifdef GRID_LINES_EN
         if ((nh_c % HW'(BSIZE) == '0) || (nv_c % HW'(BSIZE) == '0)) pix_c = 12'h222;
`endif
      end
   end

   always_ff @(posedge vgaclk) begin
      if (!rst) begin
         state       <= S_CLEAR;
         clr_idx     <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         wr_ready    <= 1'b0;
         oob_flag    <= 1'b0;
         frame_start <= 1'b0;
         red_out     <= '0;
         green_out   <= '0;
         blue_out    <= '0;
      end else begin
         case (state)
            S_CLEAR: begin
               clr_idx  <= clr_idx + AW'(1);
               wr_ready <= (clr_idx == AW'(NTILES - 1));
               if (clr_idx == AW'(NTILES - 1)) state <= S_RUN;
            end
            S_RUN: begin
               wr_ready <= (count_next_c < CW'(FIFO_DEPTH));
               if (pop_c && !head_ok_c) oob_flag <= 1'b1;
            end
            default: state <= S_CLEAR;
         endcase
         if (push_c) wr_ptr <= wr_ptr + PW'(1);
         if (pop_c) rd_ptr <= rd_ptr + PW'(1);
         count       <= count_next_c;
         frame_start <= (hc == '0) && (vc == '0);
         red_out     <= pix_c[11:8];
         green_out   <= pix_c[7:4];
         blue_out    <= pix_c[3:0];
      end
   end

endmodule

// File: tb/tb_tile_renderer.sv
// Directed bench for tile_renderer: drives hc/vc directly and checks clear, vblank commit, FIFO, palette and edges.
// Expectations follow GRID_LINES_EN when the macro is defined.

module tb_tile_renderer;

   logic       vgaclk = 1'b0;
   logic       rst = 1'b0;
   logic [9:0] hc = '0;
   logic [9:0] vc = 10'd100;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [3:0] wr_col = '0;
   logic [3:0] wr_row = '0;
   logic [3:0] wr_color = '0;
   logic       oob_flag;
   logic       frame_start;
   logic [3:0] red_out;
   logic [3:0] green_out;
   logic [3:0] blue_out;
   logic [11:0] rgb;

   int checks = 0;
   int failures = 0;

`ifdef GRID_LINES_EN
   localparam bit GRID = 1'b1;
`else
   localparam bit GRID = 1'b0;
`endif

   always #5 vgaclk = ~vgaclk;
   assign rgb = {red_out, green_out, blue_out};

   tile_renderer dut (
      .vgaclk(vgaclk), .rst(rst), .hc(hc), .vc(vc),
      .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_col(wr_col), .wr_row(wr_row), .wr_color(wr_color),
      .oob_flag(oob_flag), .frame_start(frame_start),
      .red_out(red_out), .green_out(green_out), .blue_out(blue_out)
   );

   function automatic logic [11:0] exp_px(input int nh, input int nv, input logic [11:0] c);
      bit on_grid;
      on_grid = (nh < 640) && (nv < 480) && ((nh % 40 == 0) || (nv % 40 == 0));
      return (GRID && on_grid) ? 12'h222 : c;
   endfunction

   // Raw counter inputs; outputs are sampled #1 after the following edge
   task automatic drive_raw(input int h, input int v);
      @(negedge vgaclk);
      hc = 10'(h);
      vc = 10'(v);
      @(posedge vgaclk);
      #1;
   endtask

   // Colour shown while the VGA block displays (h,v), h >= 1
   task automatic show(input int h, input int v);
      drive_raw(h - 1, v);
   endtask

   task automatic push(input int col, input int row, input int color, output bit ok);
      @(negedge vgaclk);
      wr_col = 4'(col);
      wr_row = 4'(row);
      wr_color = 4'(color);
      wr_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (wr_ready) begin
            ok = 1'b1;
            @(posedge vgaclk);
            break;
         end
         @(negedge vgaclk);
      end
      if (ok) @(negedge vgaclk);
      wr_valid = 1'b0;
   endtask

   task automatic drain();
      @(negedge vgaclk);
      vc = 10'd480;
      repeat (8) @(posedge vgaclk);
      @(negedge vgaclk);
      vc = 10'd100;
   endtask

   task automatic wait_clear(input string name);
      int n;
      n = 0;
      while (wr_ready !== 1'b1 && n < 400) begin
         @(posedge vgaclk);
         #1;
         n++;
      end
      checks++;
      if (n != 192) begin
         failures++;
         $display("FAIL %s clear_cycles got=%0d exp=192", name, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge vgaclk);
      #1;
      checks++;
      if ({wr_ready, oob_flag, frame_start} !== 3'b000 || rgb !== 12'h000) begin
         failures++;
         $display("FAIL reset_outputs got=%b%b%b rgb=%h exp=000 rgb=000", wr_ready, oob_flag, frame_start, rgb);
      end
      @(negedge vgaclk);
      rst = 1'b1;
      wait_clear("reset");
   endtask

   task automatic test_blank_map();
      int pos [4][2] = '{'{1, 0}, '{320, 240}, '{639, 479}, '{100, 400}};
      logic [11:0] e;
      for (int i = 0; i < 4; i++) begin
         show(pos[i][0], pos[i][1]);
         e = exp_px(pos[i][0], pos[i][1], 12'h000);
         checks++;
         if (rgb !== e) begin
            failures++;
            $display("FAIL blank_map[%0d] got=%h exp=%h", i, rgb, e);
         end
      end
   endtask

   task automatic test_write_commit();
      bit ok;
      int pos [5][2] = '{'{120, 80}, '{119, 80}, '{159, 119}, '{160, 119}, '{120, 120}};
      logic [11:0] col [5] = '{12'hF00, 12'h000, 12'hF00, 12'h000, 12'h000};
      logic [11:0] e;
      drive_raw(0, 100);
      push(3, 2, 4'hC, ok);
      show(121, 81);
      e = exp_px(121, 81, 12'h000);
      checks++;
      if (!ok || rgb !== e) begin
         failures++;
         $display("FAIL commit_before_vblank ok=%0d got=%h exp=%h", ok, rgb, e);
      end
      drain();
      for (int i = 0; i < 5; i++) begin
         show(pos[i][0], pos[i][1]);
         e = exp_px(pos[i][0], pos[i][1], col[i]);
         checks++;
         if (rgb !== e) begin
            failures++;
            $display("FAIL commit_px[%0d] got=%h exp=%h", i, rgb, e);
         end
      end
   endtask

   task automatic test_fifo_full();
      bit ok;
      bit all_ok;
      bit saw_ready;
      int wr [4][3] = '{'{0, 0, 1}, '{1, 0, 2}, '{0, 0, 4}, '{2, 0, 3}};
      int tl [4][2] = '{'{0, 0}, '{1, 0}, '{2, 0}, '{5, 5}};
      logic [11:0] col [4] = '{12'h800, 12'h080, 12'h088, 12'h00F};
      logic [11:0] e;
      drive_raw(0, 100);
      all_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push(wr[i][0], wr[i][1], wr[i][2], ok);
         all_ok &= ok;
      end
      checks++;
      if (!all_ok || wr_ready !== 1'b0) begin
         failures++;
         $display("FAIL fifo_full_ready accepted4=%0d got=%b exp=0", all_ok, wr_ready);
      end
      wr_col = 4'd5;
      wr_row = 4'd5;
      wr_color = 4'h9;
      wr_valid = 1'b1;
      saw_ready = 1'b0;
      repeat (3) begin
         @(negedge vgaclk);
         saw_ready |= wr_ready;
      end
      checks++;
      if (saw_ready) begin
         failures++;
         $display("FAIL fifo_hold_while_full got=1 exp=0");
      end
      vc = 10'd480;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge vgaclk);
         if (wr_ready) begin
            ok = 1'b1;
            @(posedge vgaclk);
            break;
         end
      end
      @(negedge vgaclk);
      wr_valid = 1'b0;
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL fifo_fifth_accept got=0 exp=1");
      end
      drain();
      for (int i = 0; i < 4; i++) begin
         show(tl[i][0] * 40 + 5, tl[i][1] * 40 + 5);
         e = exp_px(tl[i][0] * 40 + 5, tl[i][1] * 40 + 5, col[i]);
         checks++;
         if (rgb !== e) begin
            failures++;
            $display("FAIL fifo_order_tile[%0d] got=%h exp=%h", i, rgb, e);
         end
      end
   endtask

   task automatic test_oob();
      bit ok;
      logic [11:0] e;
      drive_raw(0, 100);
      push(0, 12, 4'h7, ok);
      checks++;
      if (!ok || oob_flag !== 1'b0) begin
         failures++;
         $display("FAIL oob_before_drain ok=%0d got=%b exp=0", ok, oob_flag);
      end
      drain();
      checks++;
      if (oob_flag !== 1'b1) begin
         failures++;
         $display("FAIL oob_after_drain got=%b exp=1", oob_flag);
      end
      show(5, 445);
      e = exp_px(5, 445, 12'h000);
      checks++;
      if (rgb !== e) begin
         failures++;
         $display("FAIL oob_map_unchanged got=%h exp=%h", rgb, e);
      end
      drain();
      checks++;
      if (oob_flag !== 1'b1) begin
         failures++;
         $display("FAIL oob_sticky got=%b exp=1", oob_flag);
      end
   endtask

   task automatic test_edges();
      bit ok;
      bit all_ok;
      int wr [4][3] = '{'{0, 0, 2}, '{0, 11, 15}, '{3, 3, 8}, '{4, 3, 7}};
      int raw [4][2] = '{'{799, 524}, '{639, 0}, '{799, 478}, '{799, 479}};
      int nxt [4][2] = '{'{0, 0}, '{640, 0}, '{0, 479}, '{0, 480}};
      logic [11:0] col [4] = '{12'h080, 12'h000, 12'hFFF, 12'h000};
      logic [11:0] e;
      drive_raw(0, 100);
      all_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push(wr[i][0], wr[i][1], wr[i][2], ok);
         all_ok &= ok;
      end
      drain();
      checks++;
      if (!all_ok) begin
         failures++;
         $display("FAIL edges_push got=0 exp=1");
      end
      for (int i = 0; i < 4; i++) begin
         drive_raw(raw[i][0], raw[i][1]);
         e = exp_px(nxt[i][0], nxt[i][1], col[i]);
         checks++;
         if (rgb !== e) begin
            failures++;
            $display("FAIL edge_px[%0d] got=%h exp=%h", i, rgb, e);
         end
      end
      show(125, 125);
      e = exp_px(125, 125, 12'h000);
      checks++;
      if (rgb !== e) begin
         failures++;
         $display("FAIL palette_idx8 got=%h exp=%h", rgb, e);
      end
      show(165, 125);
      e = exp_px(165, 125, 12'h888);
      checks++;
      if (rgb !== e) begin
         failures++;
         $display("FAIL palette_idx7 got=%h exp=%h", rgb, e);
      end
      drive_raw(0, 0);
      checks++;
      if (frame_start !== 1'b1) begin
         failures++;
         $display("FAIL frame_start_pulse got=%b exp=1", frame_start);
      end
      drive_raw(1, 0);
      checks++;
      if (frame_start !== 1'b0) begin
         failures++;
         $display("FAIL frame_start_single got=%b exp=0", frame_start);
      end
   endtask

`ifdef GRID_LINES_EN
   task automatic test_grid();
      bit ok;
      drive_raw(0, 100);
      push(1, 1, 4'hF, ok);
      drain();
      show(40, 50);
      checks++;
      if (!ok || rgb !== 12'h222) begin
         failures++;
         $display("FAIL grid_line ok=%0d got=%h exp=222", ok, rgb);
      end
      show(41, 50);
      checks++;
      if (rgb !== 12'hFFF) begin
         failures++;
         $display("FAIL grid_inside got=%h exp=fff", rgb);
      end
   endtask
`endif

   task automatic test_reset_mid();
      bit ok;
      logic [11:0] e;
      drive_raw(0, 100);
      push(0, 0, 4'hF, ok);
      @(negedge vgaclk);
      rst = 1'b0;
      @(posedge vgaclk);
      #1;
      checks++;
      if (!ok || {wr_ready, oob_flag} !== 2'b00 || rgb !== 12'h000) begin
         failures++;
         $display("FAIL reset_mid_outputs ok=%0d got=%b%b rgb=%h exp=00 rgb=000", ok, wr_ready, oob_flag, rgb);
      end
      @(negedge vgaclk);
      rst = 1'b1;
      wait_clear("reset_mid");
      drain();
      show(5, 5);
      e = exp_px(5, 5, 12'h000);
      checks++;
      if (rgb !== e) begin
         failures++;
         $display("FAIL reset_mid_recleared got=%h exp=%h", rgb, e);
      end
   endtask

   initial begin
      test_reset();
      test_blank_map();
      test_write_commit();
      test_fifo_full();
      test_oob();
      test_edges();
`ifdef GRID_LINES_EN
      test_grid();
`endif
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
